piso_16bit: RTL and testbench
=============================

# piso_16bit

Parallel-in/serial-out transmitter that drains a 16-bit word one bit at a time. It captures a parallel word on a load request and shifts it out on a single serial line, advancing only when the consumer strobes `shift_en`. It reports completion with a one-cycle `done` pulse. It sits downstream of the 16-bit load registers and is the read-out end of their parallel data path.

## Interface
- `WIDTH`, default 16: word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1:
  - 1: bit `WIDTH-1` is sent first.
  - 0: bit 0 is sent first.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset; clears all state immediately.
- `ld`  in  1: load request; accepted only at a rising edge where state is IDLE.
- `d`  in  WIDTH: parallel word; sampled only at the edge where `ld` is accepted.
- `shift_en`  in  1: advance strobe; consumed only in SHIFT.
- `sout`  out  1: current serial bit.
- `sout_valid`  out  1: high while `sout` carries a word bit.
- `busy`  out  1: high in SHIFT and DONE.
- `done`  out  1: one-cycle pulse after the last bit is consumed.

## Operation
- Storage:
  - shift register `shreg[WIDTH-1:0]`.
  - bit counter `cnt`, `$clog2(WIDTH)` bits.
  - 2-bit state: IDLE, SHIFT, DONE.
- All outputs decode from flops only. There is no combinational path from any input to any output.
- IDLE:
  - `busy`=0, `sout_valid`=0, `sout`=0, `done`=0.
  - On `ld`=1: `shreg` <= `d`, `cnt` <= 0, go to SHIFT.
- SHIFT:
  - `busy`=1, `sout_valid`=1.
  - `sout` = `shreg[WIDTH-1]` when `MSB_FIRST`=1, else `shreg[0]`.
  - `shift_en`=0: hold all state.
  - `shift_en`=1 and `cnt` != `WIDTH-1`:
    - `MSB_FIRST`=1: shift left, fill 0.
    - `MSB_FIRST`=0: shift right, fill 0.
    - `cnt` <= `cnt`+1.
  - `shift_en`=1 and `cnt` == `WIDTH-1`: go to DONE; `shreg` is cleared to 0.
- DONE:
  - Lasts exactly one cycle.
  - `done`=1, `busy`=1, `sout_valid`=0, `sout`=0.
  - Next state is IDLE unconditionally.
- `ld` in SHIFT or DONE is ignored: no capture, and the request is not queued.
- `shift_en` in IDLE or DONE is ignored.
- Reset, including mid-word:
  - state=IDLE, `shreg`=0, `cnt`=0.
  - Every output goes to 0 asynchronously.
  - The partial word is discarded; no `done` pulse.
- Reset deassertion: the first edge with `rst`=0 evaluates IDLE normally, so `ld` is accepted on that edge.

## Timing
- Reset values: `sout`=0, `sout_valid`=0, `busy`=0, `done`=0.
- Latency, with `ld` accepted at edge k:
  - First bit is valid on `sout` in the cycle after edge k.
  - `busy` and `sout_valid` rise in the same cycle.
- Bit i (0-based, in send order) is presented until the edge at which its `shift_en` is sampled high.
- With `shift_en` held at 1:
  - Bit i appears in the cycle after edge k+i.
  - `done` is high in the cycle after edge k+WIDTH.
  - IDLE is reached at edge k+WIDTH+1.
  - Earliest next accepted `ld` is at edge k+WIDTH+2.
  - Back-to-back word period is WIDTH+2 cycles.
- `shift_en` gaps stretch the bit on `sout` with no loss or duplication. `sout_valid` stays high throughout.
- Counter wrap: `cnt` never exceeds `WIDTH-1`. It is reset to 0 on every accepted load.

## Test plan
- Reset: assert `rst` asynchronously between edges → all outputs 0 immediately. With `rst` high, `ld`=1, `d`=16'hFFFF → no capture, `busy` stays 0.
- MSB-first word:
  - Stimulus: `d`=16'hA5C3 loaded, `shift_en`=1 constant.
  - `sout` over 16 cycles: 1010 0101 1100 0011.
  - `done` pulses exactly once in cycle 17 after the load edge.
  - `busy` falls at the following edge.
- LSB-first word:
  - Stimulus: `MSB_FIRST`=0, `d`=16'h0001.
  - `sout` is 1 in the first cycle, then 15 zeros.
  - `done` occurs on the same cycle timing as the MSB-first case.
- Stalls: `d`=16'h8001 with `shift_en` toggled 1,0,0,1,… → each bit holds for exactly its stall length. Sequence is intact; exactly 16 accepted strobes precede `done`.
- Ignored load: during SHIFT, pulse `ld` with `d`=16'h1234 → the word in flight is unchanged. No second word is sent after `done`.
- Mid-word reset: assert `rst` after 7 bits of 16'hFFFF → outputs 0 at once, no `done`. A fresh load of 16'h0F0F afterwards serializes correctly from its first bit.

Source files
------------

// File: rtl/piso_16bit.sv
// Parallel-in/serial-out transmitter: captures a word on ld, then drains it
// one bit per shift_en strobe and pulses done after the last bit.
module piso_16bit #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last;

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (ld) state_nx = SHIFT;
            SHIFT:   if (shift_en && last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ld) begin
                        shreg <= d;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (last) begin
                            shreg <= '0;
                            cnt   <= '0;
                        end else begin
                            shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                               : {1'b0, shreg[WIDTH-1:1]};
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    shreg <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so no input reaches them
    assign busy       = (state != IDLE);
    assign sout_valid = (state == SHIFT);
    assign done       = (state == DONE);
    assign sout       = sout_valid & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

endmodule

// File: tb/tb_piso_16bit.sv
// Bench for piso_16bit: MSB-first and LSB-first instances share stimulus and
// are compared each cycle against a queue-based reference model.
module tb_piso_16bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld = 1'b0;
    logic [15:0] d = '0;
    logic        shift_en = 1'b0;

    logic sout_m, valid_m, busy_m, done_m;
    logic sout_l, valid_l, busy_l, done_l;

    int total = 0;
    int bad   = 0;

    bit q_m[$];
    bit q_l[$];
    bit done_ph = 1'b0;

    always #5 clk = ~clk;

    piso_16bit #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .ld(ld), .d(d), .shift_en(shift_en),
        .sout(sout_m), .sout_valid(valid_m), .busy(busy_m), .done(done_m)
    );

    piso_16bit #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .ld(ld), .d(d), .shift_en(shift_en),
        .sout(sout_l), .sout_valid(valid_l), .busy(busy_l), .done(done_l)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic model_clear();
        q_m.delete();
        q_l.delete();
        done_ph = 1'b0;
    endtask

    // Reference: a word becomes a list of bits in send order; each accepted
    // strobe removes one; an emptied list yields one done cycle.
    task automatic model_edge();
        if (rst) return;
        if (done_ph) begin
            done_ph = 1'b0;
        end else if (q_m.size() > 0) begin
            if (shift_en) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
                if (q_m.size() == 0) done_ph = 1'b1;
            end
        end else if (ld) begin
            for (int i = 0; i < 16; i++) begin
                q_m.push_back(d[15-i]);
                q_l.push_back(d[i]);
            end
        end
    endtask

    task automatic check_all(input string tag);
        bit v;
        v = (q_m.size() > 0);
        chk({tag, ".sout_m"},  32'(sout_m),  32'(v ? q_m[0] : 1'b0));
        chk({tag, ".valid_m"}, 32'(valid_m), 32'(v));
        chk({tag, ".busy_m"},  32'(busy_m),  32'(v | done_ph));
        chk({tag, ".done_m"},  32'(done_m),  32'(done_ph));
        chk({tag, ".sout_l"},  32'(sout_l),  32'(v ? q_l[0] : 1'b0));
        chk({tag, ".valid_l"}, 32'(valid_l), 32'(v));
        chk({tag, ".busy_l"},  32'(busy_l),  32'(v | done_ph));
        chk({tag, ".done_l"},  32'(done_l),  32'(done_ph));
    endtask

    task automatic step(input string tag, input logic l,
                        input logic [15:0] w, input logic se);
        ld       = l;
        d        = w;
        shift_en = se;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        model_clear();
        check_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] wm;
        logic [15:0] wl;
        int strobes;
        int dones;

        #2;
        model_clear();
        check_all("reset");
        step("rst_ld", 1'b1, 16'hFFFF, 1'b1);
        rst = 1'b0;
        step("idle", 1'b0, 16'h0000, 1'b0);

        // MSB/LSB word with constant strobe; reassemble the serial streams
        step("a5c3_ld", 1'b1, 16'hA5C3, 1'b1);
        wm = '0;
        wl = '0;
        for (int i = 0; i < 16; i++) begin
            wm = {wm[14:0], sout_m};
            wl[i] = sout_l;
            step("a5c3", 1'b0, 16'h0000, 1'b1);
        end
        chk("a5c3_msb_word", 32'(wm), 32'h0000A5C3);
        chk("a5c3_lsb_word", 32'(wl), 32'h0000A5C3);
        chk("a5c3_done_c17", 32'(done_m), 32'd1);
        step("a5c3_end", 1'b0, 16'h0000, 1'b1);
        chk("a5c3_busy_fall", 32'(busy_m), 32'd0);

        step("one_ld", 1'b1, 16'h0001, 1'b1);
        for (int i = 0; i < 18; i++) step("one", 1'b0, 16'h0000, 1'b1);

        // Stalled strobe: strobe every third cycle
        step("stall_ld", 1'b1, 16'h8001, 1'b0);
        strobes = 0;
        dones   = 0;
        for (int i = 0; i < 60; i++) begin
            if (dones == 0 && valid_m && (i % 3 == 0)) strobes++;
            step("stall", 1'b0, 16'h0000, 1'(i % 3 == 0));
            if (done_m) dones++;
        end
        chk("stall_strobes", 32'(strobes), 32'd16);
        chk("stall_dones", 32'(dones), 32'd1);

        // Load request while a word is in flight must be dropped
        step("ign_ld", 1'b1, 16'hBEEF, 1'b1);
        for (int i = 0; i < 5; i++) step("ign_a", 1'b0, 16'h0000, 1'b1);
        step("ign_pulse", 1'b1, 16'h1234, 1'b1);
        for (int i = 0; i < 20; i++) step("ign_b", 1'b0, 16'h0000, 1'b1);
        chk("ign_idle", 32'(busy_m), 32'd0);

        // Reset mid-word, then a fresh word
        step("mid_ld", 1'b1, 16'hFFFF, 1'b1);
        for (int i = 0; i < 7; i++) step("mid", 1'b0, 16'h0000, 1'b1);
        async_reset("mid_rst");
        step("mid_post", 1'b0, 16'h0000, 1'b1);
        step("f0f_ld", 1'b1, 16'h0F0F, 1'b1);
        for (int i = 0; i < 18; i++) step("f0f", 1'b0, 16'h0000, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step("rnd", 1'($urandom_range(0, 3) == 0), 16'($urandom),
                 1'($urandom_range(0, 2) != 0));
            if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
